// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and defaults for the traffic-light front-end blocks.
//   db_state_e          : debounce FSM state encoding (2 bits, every code used)
//   SYNC_STAGES_DEF     : default synchroniser depth
//   DEBOUNCE_CYCLES_DEF : default count of stable samples needed to change level
// -----------------------------------------------------------------------------
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RISE_CHK = 2'd1,
      ACTIVE   = 2'd2,
      FALL_CHK = 2'd3
   } db_state_e;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

endpackage : traffic_pkg

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for a single asynchronous level signal. Reusable for
// any slow asynchronous input (loop detector, pedestrian button, ...).
// Ports:
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, clears every stage to 0
//   async_i : asynchronous input level
//   sync_o  : output of the last stage
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = chain_q[STAGES-1];

endmodule : bit_sync

// File: rtl/car_sensor_cond.sv
// -----------------------------------------------------------------------------
// car_sensor_cond
// Conditions the raw east-west vehicle-loop detector for the traffic-light
// controller: synchronise, debounce, latch a "car waiting" request until the
// east-west green has been served, and count how long the request has waited.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   sensor_raw   : raw loop detector, asynchronous, may glitch
//   ew_served    : high while east-west has green (controller ew_grn)
//   sensor_clean : debounced presence level (registered)
//   car_sensor   : latched request to the controller (registered)
//   wait_cycles  : cycles the current request has been pending, saturating
//
// Debounce FSM:
//   state    | meaning
//   IDLE     | clean level 0, sync agrees
//   RISE_CHK | clean level 0, counting consecutive sync=1 samples
//   ACTIVE   | clean level 1, sync agrees
//   FALL_CHK | clean level 1, counting consecutive sync=0 samples
// -----------------------------------------------------------------------------
module car_sensor_cond
   import traffic_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned WAIT_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sensor_raw,
   input  logic              ew_served,
   output logic              sensor_clean,
   output logic              car_sensor,
   output logic [WAIT_W-1:0] wait_cycles
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

   logic              sync;
   db_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              clean_q;
   logic              car_q, car_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (sensor_raw),
      .sync_o  (sync)
   );

   // clean_q is assigned alongside every state transition so that it always
   // reflects the state being entered (1 for ACTIVE/FALL_CHK) on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               clean_q <= 1'b0;
               if (sync) begin
                  state_q <= RISE_CHK;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            RISE_CHK: begin
               if (!sync) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  clean_q <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ACTIVE;
                  cnt_q   <= '0;
                  clean_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CNT_ONE;
                  clean_q <= 1'b0;
               end
            end
            ACTIVE: begin
               clean_q <= 1'b1;
               if (!sync) begin
                  state_q <= FALL_CHK;
                  cnt_q   <= CNT_ONE;
               end
            end
            FALL_CHK: begin
               if (sync) begin
                  state_q <= ACTIVE;
                  cnt_q   <= '0;
                  clean_q <= 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  clean_q <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + CNT_ONE;
                  clean_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               clean_q <= 1'b0;
            end
         endcase
      end
   end

   // Served wins over presence; otherwise the request is sticky even if the
   // car drives away before getting green.
   always_comb begin
      car_d = car_q;
      if (ew_served) begin
         car_d = 1'b0;
      end else if (clean_q) begin
         car_d = 1'b1;
      end
   end

   always_comb begin
      wait_d = '0;
      if (car_q) begin
         wait_d = (wait_q == WAIT_MAX) ? WAIT_MAX : wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_q  <= 1'b0;
         wait_q <= '0;
      end else begin
         car_q  <= car_d;
         wait_q <= wait_d;
      end
   end

   assign sensor_clean = clean_q;
   assign car_sensor   = car_q;
   assign wait_cycles  = wait_q;

endmodule : car_sensor_cond

// File: tb/tb_car_sensor_cond.sv
module tb_car_sensor_cond;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int WW   = 8;
   localparam logic [WW-1:0] WMAX = {WW{1'b1}};

   logic          clk;
   logic          rst_n;
   logic          sensor_raw;
   logic          ew_served;
   logic          sensor_clean;
   logic          car_sensor;
   logic [WW-1:0] wait_cycles;

   int n_cmp = 0;
   int n_err = 0;

   car_sensor_cond #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .WAIT_W          (WW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sensor_raw   (sensor_raw),
      .ew_served    (ew_served),
      .sensor_clean (sensor_clean),
      .car_sensor   (car_sensor),
      .wait_cycles  (wait_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: sync is the raw level delayed by SYNC samples; the clean
   // level flips once DEB consecutive sync samples disagree with it; the
   // request and wait counter follow their rules from the previous-cycle values.
   logic [SYNC-1:0] m_sh;
   int              m_run;
   logic            m_clean, m_car, m_s;
   logic [WW-1:0]   m_wait;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sh = '0; m_run = 0; m_clean = 1'b0; m_car = 1'b0; m_wait = '0;
      end else begin
         m_s    = m_sh[SYNC-1];
         m_wait = m_car ? ((m_wait == WMAX) ? WMAX : m_wait + 1'b1) : '0;
         m_car  = ew_served ? 1'b0 : (m_clean ? 1'b1 : m_car);
         if (m_s != m_clean) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
               m_clean = m_s;
               m_run   = 0;
            end
         end else begin
            m_run = 0;
         end
         m_sh = {m_sh[SYNC-2:0], sensor_raw};
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; sensor_raw = 1'b0; ew_served = 1'b0;
      #3;
      n_cmp++;
      if ({sensor_clean, car_sensor, wait_cycles} !== {1'b0, 1'b0, {WW{1'b0}}}) begin
         n_err++;
         $display("FAIL reset_values: got clean=%0b car=%0b wait=%0d, want 0/0/0",
                  sensor_clean, car_sensor, wait_cycles);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({sensor_clean, car_sensor, wait_cycles} !== {m_clean, m_car, m_wait}) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: got %0b/%0b/%0d, want %0b/%0b/%0d", k,
                     sensor_clean, car_sensor, wait_cycles, m_clean, m_car, m_wait);
         end
      end
   endtask

   task automatic test_clean_press();
      int exp_w;
      sensor_raw = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         exp_w = (k >= 7) ? k - 6 : 0;
         n_cmp++;
         if (sensor_clean !== (k >= 5) || car_sensor !== (k >= 6) || wait_cycles !== WW'(exp_w)) begin
            n_err++;
            $display("FAIL clean_press[edge %0d]: got %0b/%0b/%0d, want %0b/%0b/%0d", k,
                     sensor_clean, car_sensor, wait_cycles, (k >= 5), (k >= 6), exp_w);
         end
      end
      sensor_raw = 1'b0;
      for (int k = 0; k < 10; k++) @(negedge clk);
      ew_served = 1'b1;
      @(negedge clk);
      ew_served = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({sensor_clean, car_sensor, wait_cycles} !== {m_clean, m_car, m_wait}) begin
            n_err++;
            $display("FAIL press_clear[%0d]: got %0b/%0b/%0d, want %0b/%0b/%0d", k,
                     sensor_clean, car_sensor, wait_cycles, m_clean, m_car, m_wait);
         end
      end
   endtask

   task automatic test_glitch();
      sensor_raw = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (k == 2) sensor_raw = 1'b0;
         n_cmp++;
         if ({sensor_clean, car_sensor, wait_cycles} !== {1'b0, 1'b0, {WW{1'b0}}}) begin
            n_err++;
            $display("FAIL glitch_reject[%0d]: got %0b/%0b/%0d, want 0/0/0", k,
                     sensor_clean, car_sensor, wait_cycles);
         end
      end
      sensor_raw = 1'b1;
      for (int k = 0; k < 8; k++) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         sensor_raw = !(k < 3);
         @(negedge clk);
         n_cmp++;
         if (sensor_clean !== 1'b1) begin
            n_err++;
            $display("FAIL dropout_hold[%0d]: got clean=%0b, want 1", k, sensor_clean);
         end
      end
      sensor_raw = 1'b0;
      for (int k = 0; k < 10; k++) @(negedge clk);
      ew_served = 1'b1;
      @(negedge clk);
      ew_served = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latch_serve();
      sensor_raw = 1'b1;
      for (int k = 0; k < 10; k++) @(negedge clk);
      sensor_raw = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         n_cmp++;
         if (car_sensor !== 1'b1 || car_sensor !== m_car) begin
            n_err++;
            $display("FAIL latch_hold[%0d]: got car=%0b, want 1", k, car_sensor);
         end
      end
      ew_served = 1'b1;
      @(negedge clk);
      ew_served = 1'b0;
      n_cmp++;
      if (car_sensor !== 1'b0 || wait_cycles === '0) begin
         n_err++;
         $display("FAIL serve_drop: got car=%0b wait=%0d, want car=0 wait>0", car_sensor, wait_cycles);
      end
      @(negedge clk);
      n_cmp++;
      if (wait_cycles !== '0 || car_sensor !== 1'b0) begin
         n_err++;
         $display("FAIL serve_wait_clear: got car=%0b wait=%0d, want 0/0", car_sensor, wait_cycles);
      end
   endtask

   task automatic test_simultaneous();
      sensor_raw = 1'b1;
      for (int k = 0; k < 10; k++) @(negedge clk);
      ew_served = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (car_sensor !== 1'b0 || sensor_clean !== 1'b1) begin
            n_err++;
            $display("FAIL simul_served[%0d]: got car=%0b clean=%0b, want 0/1", k, car_sensor, sensor_clean);
         end
      end
      ew_served = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (car_sensor !== 1'b1) begin
         n_err++;
         $display("FAIL simul_reassert: got car=%0b, want 1", car_sensor);
      end
   endtask

   task automatic test_saturation();
      logic [WW-1:0] prev;
      sensor_raw = 1'b0;
      prev = wait_cycles;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         n_cmp++;
         if (wait_cycles < prev || wait_cycles !== m_wait) begin
            n_err++;
            $display("FAIL saturate[%0d]: got wait=%0d prev=%0d, want %0d (non-decreasing)",
                     k, wait_cycles, prev, m_wait);
         end
         prev = wait_cycles;
      end
      n_cmp++;
      if (wait_cycles !== WMAX) begin
         n_err++;
         $display("FAIL saturate_final: got wait=%0d, want %0d", wait_cycles, WMAX);
      end
      ew_served = 1'b1;
      @(negedge clk);
      ew_served = 1'b0;
      for (int k = 0; k < 10; k++) @(negedge clk);
   endtask

   task automatic test_async_reset();
      sensor_raw = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sensor_clean, car_sensor, wait_cycles} !== {1'b0, 1'b0, {WW{1'b0}}}) begin
         n_err++;
         $display("FAIL reset_mid_rise: got %0b/%0b/%0d, want 0/0/0", sensor_clean, car_sensor, wait_cycles);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sensor_clean !== (k >= 5) || car_sensor !== m_car || wait_cycles !== m_wait) begin
            n_err++;
            $display("FAIL post_reset_rise[edge %0d]: got %0b/%0b/%0d, want %0b/%0b/%0d", k,
                     sensor_clean, car_sensor, wait_cycles, (k >= 5), m_car, m_wait);
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sensor_clean, car_sensor, wait_cycles} !== {1'b0, 1'b0, {WW{1'b0}}}) begin
         n_err++;
         $display("FAIL reset_mid_request: got %0b/%0b/%0d, want 0/0/0", sensor_clean, car_sensor, wait_cycles);
      end
      @(negedge clk);
      sensor_raw = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) @(negedge clk);
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int k = 0; k < 800; k++) begin
         if (hold == 0) begin
            sensor_raw = $urandom_range(1, 0) == 1;
            hold = $urandom_range(9, 1);
         end
         hold--;
         ew_served = ($urandom_range(11, 0) == 0);
         @(negedge clk);
         n_cmp++;
         if ({sensor_clean, car_sensor, wait_cycles} !== {m_clean, m_car, m_wait}) begin
            n_err++;
            $display("FAIL random[%0d]: got %0b/%0b/%0d, want %0b/%0b/%0d", k,
                     sensor_clean, car_sensor, wait_cycles, m_clean, m_car, m_wait);
         end
      end
      ew_served = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_latch_serve();
      test_simultaneous();
      test_saturation();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_car_sensor_cond

// File: doc/car_sensor_cond.md
Name: car_sensor_cond

Overview:
- Conditions the raw east-west vehicle-loop detector before it reaches the traffic-light controller's car_sensor input.
- Synchronises the asynchronous loop signal and debounces it with a 4-state FSM.
- Latches a "car waiting" request until the controller reports that east-west green has been served.
- Also reports a saturating wait-time count for status and debug.

Parameters:
SYNC_STAGES, 2, synchroniser flop count (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change the clean level (>=2)
WAIT_W, 8, width of wait_cycles counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sensor_raw  in  1  raw loop detector, asynchronous to clk, may glitch
ew_served  in  1  high while east-west has green; driven from controller ew_grn
sensor_clean  out  1  debounced presence level
car_sensor  out  1  latched request to controller
wait_cycles  out  WAIT_W  cycles the current request has been pending, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all synchroniser flops 0, debounce state IDLE, debounce count 0, sensor_clean 0, car_sensor 0, wait_cycles 0.
- Reset asserted mid-operation clears everything immediately, with no clock required.
- Synchroniser: SYNC_STAGES flops in series. sync is the last flop's output.
- Debounce FSM: states IDLE, RISE_CHK, ACTIVE, FALL_CHK. Count cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - IDLE: sync=1 -> RISE_CHK, cnt=1. Otherwise stay, cnt=0.
  - RISE_CHK: sync=0 -> IDLE, cnt=0 (glitch rejected). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> ACTIVE, cnt=0. Otherwise cnt+1.
  - ACTIVE: sync=0 -> FALL_CHK, cnt=1. Otherwise stay.
  - FALL_CHK: sync=1 -> ACTIVE, cnt=0. sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0. Otherwise cnt+1.
  - Illegal state encoding -> IDLE.
- sensor_clean is registered and equals (state==ACTIVE || state==FALL_CHK). It asserts on the same edge the FSM enters ACTIVE.
- Rise latency: sensor_raw high and stable before edge 0 -> sensor_clean is 1 after edge SYNC_STAGES-1+DEBOUNCE_CYCLES (edge 5 with defaults). Fall latency is symmetric.
- Pulses on sync shorter than DEBOUNCE_CYCLES cycles never change sensor_clean.
- Request latch (registered car_sensor), evaluated each edge in priority order:
  - ew_served=1 -> 0 (served wins over a simultaneous presence).
  - else sensor_clean=1 -> 1.
  - else hold.
  - A car that leaves before being served keeps the request pending.
  - A car still present after ew_served falls re-asserts car_sensor one cycle later.
- wait_cycles (registered):
  - If car_sensor==0, next value is 0.
  - Else it increments each cycle and saturates at 2^WAIT_W-1, never wrapping.
  - Clears on the cycle after car_sensor falls.
- No combinational path from any input to any output. All outputs come straight from flops.

Decomposition:
- Package traffic_pkg holds the debounce state enum (2-bit: IDLE=0, RISE_CHK=1, ACTIVE=2, FALL_CHK=3) and the default constants DEBOUNCE_CYCLES_DEF=4 and SYNC_STAGES_DEF=2.
- Sub-module bit_sync: parameterised STAGES flop chain with asynchronous active-low reset to 0. It is reusable for other asynchronous inputs such as a pedestrian button.
- The debounce FSM, request latch and wait counter stay in car_sensor_cond.

Test Plan:
- Clean press: sensor_raw 0->1 before edge 0, held 20 cycles -> sensor_clean rises after edge 5; car_sensor rises after edge 6; wait_cycles reads 1 after edge 7.
- Glitch rejection: sensor_raw high for 3 cycles then low -> sensor_clean, car_sensor and wait_cycles stay 0 throughout. A dropout of 3 cycles while ACTIVE -> sensor_clean stays 1.
- Latch and serve: car present 10 cycles, then absent 30 cycles -> car_sensor stays 1. Pulse ew_served for 1 cycle -> car_sensor 0 next edge, wait_cycles 0 the edge after.
- Simultaneous: sensor_clean=1 and ew_served=1 for 5 cycles -> car_sensor 0 throughout. ew_served drops with car still present -> car_sensor 1 next edge.
- Saturation: request pending 300 cycles with WAIT_W=8 -> wait_cycles reaches 255 and holds at 255, no wrap.
- Async reset: assert rst_n=0 mid-RISE_CHK and separately mid-request, between clock edges -> all outputs 0 immediately. After release with sensor_raw still high, full rise latency (6 edges) is required before sensor_clean asserts.
